// File: rtl/jt6295_voice_core_if.sv
// Signal bundle between the voice core and its environment (CPU, ROM, channel pipe).
interface jt6295_voice_core_if;
  logic              cen;
  logic              cen4;
  logic              wrn;
  logic [7:0]        din;
  logic [9:0]        rom_addr;
  logic [7:0]        rom_data;
  logic              rom_ok;
  logic [17:0]       start_addr;
  logic [17:0]       stop_addr;
  logic [3:0]        att;
  logic [3:0]        start;
  logic [3:0]        stop;
  logic [3:0]        busy;
  logic [3:0]        ack;
  logic              zero;
  logic              pipe_en;
  logic [3:0]        pipe_att;
  logic [3:0]        pipe_data;
  logic signed [13:0] sound;
  logic              sample;

  // Environment side: enables, CPU port, ROM data, channel status and pipe
  modport master (
    output cen, cen4, wrn, din, rom_data, rom_ok, busy, ack,
           pipe_en, pipe_att, pipe_data,
    input  rom_addr, start_addr, stop_addr, att, start, stop, zero,
           sound, sample
  );

  // Core side
  modport slave (
    input  cen, cen4, wrn, din, rom_data, rom_ok, busy, ack,
           pipe_en, pipe_att, pipe_data,
    output rom_addr, start_addr, stop_addr, att, start, stop, zero,
           sound, sample
  );
endinterface

// File: rtl/jt6295_voice_core.sv
// MSM6295-style command decoder, 4-channel ADPCM decoder and output mixer.
module jt6295_voice_core (
  input  logic                 clk,
  input  logic                 rst,
  jt6295_voice_core_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, PHRASE, FETCH, START} state_t;

  state_t       state, state_nxt;
  logic         wrn_l;
  logic         we;
  logic [6:0]   phrase;
  logic [3:0]   mask;
  logic [2:0]   byte_cnt;
  logic         fetch_wait;
  logic         byte_ok;

  // ADPCM step size for a given index
  function automatic logic [10:0] step_lut(input logic [5:0] idx);
    case (idx)
      6'd0: step_lut = 11'd16;    6'd1: step_lut = 11'd17;    6'd2: step_lut = 11'd19;
      6'd3: step_lut = 11'd21;    6'd4: step_lut = 11'd23;    6'd5: step_lut = 11'd25;
      6'd6: step_lut = 11'd28;    6'd7: step_lut = 11'd31;    6'd8: step_lut = 11'd34;
      6'd9: step_lut = 11'd37;    6'd10: step_lut = 11'd41;   6'd11: step_lut = 11'd45;
      6'd12: step_lut = 11'd50;   6'd13: step_lut = 11'd55;   6'd14: step_lut = 11'd60;
      6'd15: step_lut = 11'd66;   6'd16: step_lut = 11'd73;   6'd17: step_lut = 11'd80;
      6'd18: step_lut = 11'd88;   6'd19: step_lut = 11'd97;   6'd20: step_lut = 11'd107;
      6'd21: step_lut = 11'd118;  6'd22: step_lut = 11'd130;  6'd23: step_lut = 11'd143;
      6'd24: step_lut = 11'd157;  6'd25: step_lut = 11'd173;  6'd26: step_lut = 11'd190;
      6'd27: step_lut = 11'd209;  6'd28: step_lut = 11'd230;  6'd29: step_lut = 11'd253;
      6'd30: step_lut = 11'd279;  6'd31: step_lut = 11'd307;  6'd32: step_lut = 11'd337;
      6'd33: step_lut = 11'd371;  6'd34: step_lut = 11'd408;  6'd35: step_lut = 11'd449;
      6'd36: step_lut = 11'd494;  6'd37: step_lut = 11'd544;  6'd38: step_lut = 11'd598;
      6'd39: step_lut = 11'd658;  6'd40: step_lut = 11'd724;  6'd41: step_lut = 11'd796;
      6'd42: step_lut = 11'd876;  6'd43: step_lut = 11'd963;  6'd44: step_lut = 11'd1060;
      6'd45: step_lut = 11'd1166; 6'd46: step_lut = 11'd1282; 6'd47: step_lut = 11'd1411;
      default: step_lut = 11'd1552;
    endcase
  endfunction

  // Linear gain (x/32) for an attenuation code; codes above 8 mute
  function automatic logic [5:0] gain_lut(input logic [3:0] a);
    case (a)
      4'd0: gain_lut = 6'd32; 4'd1: gain_lut = 6'd23; 4'd2: gain_lut = 6'd16;
      4'd3: gain_lut = 6'd11; 4'd4: gain_lut = 6'd8;  4'd5: gain_lut = 6'd6;
      4'd6: gain_lut = 6'd4;  4'd7: gain_lut = 6'd3;  4'd8: gain_lut = 6'd2;
      default: gain_lut = 6'd0;
    endcase
  endfunction

  assign we      = wrn_l & ~bus.wrn;
  assign byte_ok = (state == FETCH) && !fetch_wait && bus.rom_ok;

  // Command FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Command FSM next state
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (we && bus.din[7]) state_nxt = PHRASE;
      PHRASE:  if (we) state_nxt = FETCH;
      FETCH:   if (byte_ok && byte_cnt == 3'd5) state_nxt = START;
      START:   if (bus.start == 4'd0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Command datapath: phrase latch, stop pulse, phrase-table fetch, start handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrn_l          <= 1'b1;
      phrase         <= '0;
      mask           <= '0;
      byte_cnt       <= '0;
      fetch_wait     <= 1'b0;
      bus.zero       <= 1'b0;
      bus.stop       <= '0;
      bus.start      <= '0;
      bus.att        <= '0;
      bus.rom_addr   <= '0;
      bus.start_addr <= '0;
      bus.stop_addr  <= '0;
    end else begin
      wrn_l    <= bus.wrn;
      bus.stop <= '0;
      case (state)
        IDLE: begin
          if (we) begin
            if (bus.din[7]) begin
              phrase   <= bus.din[6:0];
              bus.zero <= (bus.din[6:0] == 7'd0);
            end else begin
              bus.stop <= bus.din[6:3];
            end
          end
        end
        PHRASE: begin
          if (we) begin
            mask         <= bus.din[7:4];
            bus.att      <= bus.din[3:0];
            byte_cnt     <= '0;
            bus.rom_addr <= {phrase, 3'd0};
            fetch_wait   <= 1'b1;
          end
        end
        FETCH: begin
          if (fetch_wait) begin
            // ROM needs a clk to present data for the new address
            fetch_wait <= 1'b0;
          end else if (bus.rom_ok) begin
            case (byte_cnt)
              3'd0:    bus.start_addr[17:16] <= bus.rom_data[1:0];
              3'd1:    bus.start_addr[15:8]  <= bus.rom_data;
              3'd2:    bus.start_addr[7:0]   <= bus.rom_data;
              3'd3:    bus.stop_addr[17:16]  <= bus.rom_data[1:0];
              3'd4:    bus.stop_addr[15:8]   <= bus.rom_data;
              default: bus.stop_addr[7:0]    <= bus.rom_data;
            endcase
            if (byte_cnt == 3'd5) begin
              bus.start <= mask & ~bus.busy;
            end else begin
              byte_cnt     <= 3'(byte_cnt + 3'd1);
              bus.rom_addr <= {phrase, 3'(byte_cnt + 3'd1)};
              fetch_wait   <= 1'b1;
            end
          end
        end
        default: bus.start <= bus.start & ~bus.ack;
      endcase
    end
  end

  // Per-channel decoder state and mixer registers
  logic signed [11:0] sig_mem [4];
  logic [5:0]         idx_mem [4];
  logic [1:0]         slot, slot_cur;
  logic signed [11:0] sig_old, sig_new;
  logic [5:0]         idx_old, idx_new;
  logic [10:0]        step;
  logic [12:0]        diff;
  logic signed [13:0] sig_sum;
  logic signed [6:0]  idx_delta, idx_sum;
  logic [5:0]         gain;
  logic signed [18:0] prod;
  logic signed [13:0] val_nxt, pend, acc;

  // ADPCM decode and attenuation of the current slot
  always_comb begin
    slot_cur = bus.cen ? 2'd0 : slot;
    sig_old  = sig_mem[slot_cur];
    idx_old  = idx_mem[slot_cur];
    step     = step_lut(idx_old);
    diff     = 13'(step >> 3);
    if (bus.pipe_data[0]) diff = diff + 13'(step >> 2);
    if (bus.pipe_data[1]) diff = diff + 13'(step >> 1);
    if (bus.pipe_data[2]) diff = diff + 13'(step);
    if (bus.pipe_data[3]) sig_sum = $signed({{2{sig_old[11]}}, sig_old}) - $signed({1'b0, diff});
    else                  sig_sum = $signed({{2{sig_old[11]}}, sig_old}) + $signed({1'b0, diff});
    if (sig_sum > 14'sd2047)       sig_new = 12'sd2047;
    else if (sig_sum < -14'sd2048) sig_new = -12'sd2048;
    else                           sig_new = sig_sum[11:0];
    case (bus.pipe_data[2:0])
      3'd4:    idx_delta = 7'sd2;
      3'd5:    idx_delta = 7'sd4;
      3'd6:    idx_delta = 7'sd6;
      3'd7:    idx_delta = 7'sd8;
      default: idx_delta = -7'sd1;
    endcase
    idx_sum = $signed({1'b0, idx_old}) + idx_delta;
    if (idx_sum < 7'sd0)       idx_new = 6'd0;
    else if (idx_sum > 7'sd48) idx_new = 6'd48;
    else                       idx_new = idx_sum[5:0];
    gain    = gain_lut(bus.pipe_att);
    prod    = $signed({{7{sig_new[11]}}, sig_new}) * $signed({13'd0, gain});
    val_nxt = bus.pipe_en ? 14'(prod >>> 5) : 14'sd0;
  end

  // Slot counter, channel state update, one-slot pipeline and frame accumulator
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        sig_mem[i] <= '0;
        idx_mem[i] <= '0;
      end
      slot       <= '0;
      pend       <= '0;
      acc        <= '0;
      bus.sound  <= '0;
      bus.sample <= 1'b0;
    end else begin
      bus.sample <= 1'b0;
      if (bus.cen4) begin
        slot              <= 2'(slot_cur + 2'd1);
        sig_mem[slot_cur] <= bus.pipe_en ? sig_new : 12'sd0;
        idx_mem[slot_cur] <= bus.pipe_en ? idx_new : 6'd0;
        pend              <= val_nxt;
        if (bus.cen) begin
          bus.sound  <= acc;
          bus.sample <= 1'b1;
          acc        <= pend;
        end else begin
          acc <= 14'(acc + pend);
        end
      end
    end
  end

endmodule

// File: tb/tb_jt6295_voice_core.sv
// Directed bench for jt6295_voice_core: command decoding, ADPCM decode, attenuation, mixing.
module tb_jt6295_voice_core;

  logic clk;
  logic rst;
  jt6295_voice_core_if bus ();

  jt6295_voice_core dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    logic [3:0] nib;
    logic [3:0] att;
    int         exp;
  } att_vec_t;

  int         checks = 0;
  int         errors = 0;
  int         stop_cnt = 0;
  int         sample_cnt = 0;
  logic [3:0] last_stop = '0;
  logic [7:0] rom_mem [1024];
  logic       ch_en  [4];
  logic [3:0] ch_att [4];
  logic [3:0] ch_dat [4];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // cen4 every other clk, cen every 8 clks; present the upcoming slot's channel data
  initial begin
    logic [2:0] cnt;
    logic [1:0] s;
    cnt = '0;
    bus.cen = 1'b0; bus.cen4 = 1'b0;
    bus.pipe_en = 1'b0; bus.pipe_att = '0; bus.pipe_data = '0;
    forever begin
      @(negedge clk);
      cnt = 3'(cnt + 3'd1);
      s = cnt[2:1];
      bus.cen4      = (cnt[0] == 1'b0);
      bus.cen       = (cnt == 3'd0);
      bus.pipe_en   = ch_en[s];
      bus.pipe_att  = ch_att[s];
      bus.pipe_data = ch_dat[s];
    end
  end

  // ROM model with irregular valid
  initial begin
    bus.rom_data = '0; bus.rom_ok = 1'b0;
    forever begin
      @(negedge clk);
      bus.rom_data = rom_mem[bus.rom_addr];
      bus.rom_ok   = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitors for stop pulses and sample pulses
  initial begin
    forever begin
      @(negedge clk);
      if (bus.stop != 4'd0) begin
        stop_cnt++;
        last_stop = bus.stop;
      end
      if (bus.sample === 1'b1) sample_cnt++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cpu_write(input logic [7:0] d);
    @(negedge clk);
    bus.wrn = 1'b0; bus.din = d;
    @(negedge clk);
    bus.wrn = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_start();
    bit found;
    found = 1'b0;
    for (int n = 0; n < 200 && !found; n++) begin
      @(negedge clk);
      if (bus.start != 4'd0) found = 1'b1;
    end
    check("start_seen", int'(found), 1);
  endtask

  task automatic wait_sample(output int v);
    bit found;
    found = 1'b0;
    v = 0;
    for (int n = 0; n < 64 && !found; n++) begin
      @(negedge clk);
      if (bus.sample === 1'b1) begin
        found = 1'b1;
        v = int'(bus.sound);
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL sample_timeout: got no pulse expected one within 64 clks");
    end
  endtask

  task automatic next_nonzero(output int v);
    bit found;
    found = 1'b0;
    v = 0;
    for (int k = 0; k < 40 && !found; k++) begin
      wait_sample(v);
      if (v != 0) found = 1'b1;
    end
    check("nonzero_seen", int'(found), 1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    att_vec_t vecs [17];
    int v;

    vecs[0]  = '{4'd7,  4'd0,  2047};
    vecs[1]  = '{4'd7,  4'd1,  1471};
    vecs[2]  = '{4'd7,  4'd2,  1023};
    vecs[3]  = '{4'd7,  4'd3,  703};
    vecs[4]  = '{4'd7,  4'd4,  511};
    vecs[5]  = '{4'd7,  4'd5,  383};
    vecs[6]  = '{4'd7,  4'd6,  255};
    vecs[7]  = '{4'd7,  4'd7,  191};
    vecs[8]  = '{4'd7,  4'd8,  127};
    vecs[9]  = '{4'd7,  4'd9,  0};
    vecs[10] = '{4'd7,  4'd15, 0};
    vecs[11] = '{4'd15, 4'd0,  -2048};
    vecs[12] = '{4'd15, 4'd1,  -1472};
    vecs[13] = '{4'd15, 4'd3,  -704};
    vecs[14] = '{4'd15, 4'd6,  -256};
    vecs[15] = '{4'd15, 4'd8,  -128};
    vecs[16] = '{4'd15, 4'd12, 0};

    for (int i = 0; i < 4; i++) begin
      ch_en[i] = 1'b0; ch_att[i] = '0; ch_dat[i] = '0;
    end
    for (int i = 0; i < 1024; i++) rom_mem[i] = '0;
    rom_mem[8]  = 8'h00; rom_mem[9]  = 8'h10; rom_mem[10] = 8'h00;
    rom_mem[11] = 8'h00; rom_mem[12] = 8'h20; rom_mem[13] = 8'h00;
    rom_mem[0]  = 8'h03; rom_mem[1]  = 8'h12; rom_mem[2]  = 8'h34;
    rom_mem[3]  = 8'h01; rom_mem[4]  = 8'hAB; rom_mem[5]  = 8'hCD;
    bus.wrn = 1'b1; bus.din = '0; bus.busy = '0; bus.ack = '0;

    do_reset();
    check("rst_start",      int'(bus.start), 0);
    check("rst_stop",       int'(bus.stop), 0);
    check("rst_att",        int'(bus.att), 0);
    check("rst_start_addr", int'(bus.start_addr), 0);
    check("rst_stop_addr",  int'(bus.stop_addr), 0);
    check("rst_rom_addr",   int'(bus.rom_addr), 0);
    check("rst_zero",       int'(bus.zero), 0);
    check("rst_sound",      int'(bus.sound), 0);
    check("rst_sample",     int'(bus.sample), 0);

    // Phrase 1 start with att 2 on ch0
    cpu_write(8'h81);
    cpu_write(8'h12);
    wait_start();
    check("p1_start",      int'(bus.start), 1);
    check("p1_start_addr", int'(bus.start_addr), 32'h01000);
    check("p1_stop_addr",  int'(bus.stop_addr), 32'h02000);
    check("p1_att",        int'(bus.att), 2);
    check("p1_zero",       int'(bus.zero), 0);
    repeat (3) @(negedge clk);
    check("p1_start_hold", int'(bus.start), 1);
    bus.ack = 4'b0001;
    @(negedge clk);
    bus.ack = 4'b0000;
    repeat (2) @(negedge clk);
    check("p1_start_ack", int'(bus.start), 0);

    // Stop commands issued from IDLE
    stop_cnt = 0;
    cpu_write(8'h78);
    repeat (3) @(negedge clk);
    check("stop_all_cnt", stop_cnt, 1);
    check("stop_all_val", int'(last_stop), 15);
    stop_cnt = 0;
    cpu_write(8'h10);
    repeat (3) @(negedge clk);
    check("stop_ch1_cnt", stop_cnt, 1);
    check("stop_ch1_val", int'(last_stop), 2);

    // Phrase 0 with ch1 busy
    bus.busy = 4'b0010;
    cpu_write(8'h80);
    check("p0_zero", int'(bus.zero), 1);
    cpu_write(8'h30);
    wait_start();
    check("p0_start",      int'(bus.start), 1);
    check("p0_start_addr", int'(bus.start_addr), 32'h31234);
    check("p0_stop_addr",  int'(bus.stop_addr), 32'h1ABCD);
    check("p0_att",        int'(bus.att), 0);
    // Write while waiting for ack must be ignored
    stop_cnt = 0;
    cpu_write(8'h08);
    repeat (2) @(negedge clk);
    check("start_drop_wr", stop_cnt, 0);
    check("start_held",    int'(bus.start), 1);
    bus.busy = 4'b0000;
    // Reset abandons the pending start
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_start", int'(bus.start), 0);
    rst = 1'b0;
    @(negedge clk);

    // Decode: nibble 0 on ch0, att 0
    ch_en[0] = 1'b1; ch_att[0] = 4'd0; ch_dat[0] = 4'd0;
    do_reset();
    next_nonzero(v); check("dec0_a", v, 2);
    wait_sample(v);  check("dec0_b", v, 4);
    wait_sample(v);  check("dec0_c", v, 6);

    // Decode: nibble 7 from reset
    ch_dat[0] = 4'd7;
    do_reset();
    next_nonzero(v); check("dec7_a", v, 30);
    wait_sample(v);  check("dec7_b", v, 93);
    repeat (20) wait_sample(v);
    check("dec7_sat", v, 2047);

    // Step index saturated at 48: first decrease uses step 1552, next 1411
    ch_dat[0] = 4'd8;
    begin
      bit found;
      found = 1'b0;
      for (int k = 0; k < 10 && !found; k++) begin
        wait_sample(v);
        if (v != 2047) found = 1'b1;
      end
      check("idx48_dec", v, 1853);
    end
    wait_sample(v); check("idx47_dec", v, 1677);

    // Attenuation table at saturated signal
    for (int i = 0; i < 17; i++) begin
      ch_dat[0] = vecs[i].nib;
      ch_att[0] = vecs[i].att;
      repeat (12) wait_sample(v);
      check($sformatf("att_vec%0d", i), v, vecs[i].exp);
    end

    // Mix of four saturated channels
    for (int i = 0; i < 4; i++) begin
      ch_en[i] = 1'b1; ch_att[i] = 4'd0; ch_dat[i] = 4'd7;
    end
    repeat (15) wait_sample(v);
    check("mix_full", v, 8188);
    wait_sample(v);
    sample_cnt = 0;
    repeat (80) @(negedge clk);
    check("sample_rate", sample_cnt, 10);
    wait_sample(v);
    for (int i = 0; i < 4; i++) ch_en[i] = 1'b0;
    wait_sample(v);
    wait_sample(v);
    check("mix_off", v, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/jt6295_voice_core.md
# jt6295_voice_core

Command decoder, ADPCM decoder and output mixer of the MSM6295-compatible sound engine. It sits between the CPU write port and the ADPCM fetch/serialiser stage, which is external. It parses CPU phrase/stop commands and reads the phrase table from ROM. It then decodes the serialised 4-bit ADPCM nibbles of four time-multiplexed channels with attenuation, and sums them into one 14-bit sample per sample period.

## Interface
- No parameters. The output is non-interpolated.
- `clk`  in  1  system clock.
- `rst`  in  1  reset; asynchronous, active-high.
- `cen`  in  1  sample-rate enable (1x). Coincides with every 4th `cen4`.
- `cen4`  in  1  channel-slot enable (4x sample rate).
- `wrn`  in  1  CPU write strobe, active low.
- `din`  in  8  CPU write data.
- `rom_addr`  out  10  phrase-table byte address, `{phrase[6:0], byte[2:0]}`.
- `rom_data`  in  8  ROM byte.
- `rom_ok`  in  1  `rom_data` is valid for the current `rom_addr`.
- `start_addr`  out  18  phrase start address.
- `stop_addr`  out  18  phrase stop address.
- `att`  out  4  attenuation of the pending start.
- `start`  out  4  per-channel start request; each bit holds until its `ack` bit.
- `stop`  out  4  per-channel stop pulse, one clk wide.
- `busy`  in  4  channel is playing.
- `ack`  in  4  channel accepted its start request.
- `zero`  out  1  latched phrase number is 0.
- `pipe_en`  in  1  current slot's channel is active.
- `pipe_att`  in  4  current slot's attenuation.
- `pipe_data`  in  4  current slot's ADPCM nibble.
- `sound`  out  14 signed  mixed output.
- `sample`  out  1  one-clk pulse when `sound` updates.

## Operation
- **Write detect.** A write is registered on the clk where `wrn` was 1 on the previous clk and is 0 now.
- **Command FSM states:** IDLE, PHRASE, FETCH, START.
- **IDLE, write with `din[7]=1`:** latch `phrase=din[6:0]`, set `zero=(din[6:0]==0)`, go to PHRASE.
- **IDLE, write with `din[7]=0`:** `stop<=din[6:3]` for one clk (bit 3 → ch0 … bit 6 → ch3). Stay in IDLE.
- **PHRASE, write:** latch `mask=din[7:4]` (bit 4 → ch0) and `att=din[3:0]`, clear the byte counter, go to FETCH.
- **FETCH:** drive `rom_addr={phrase,byte}` for bytes 0..5.
  - A byte is latched on the first clk with `rom_ok=1` that comes at least one clk after the address changed.
  - Bytes 0..2 form `start_addr` and bytes 3..5 form `stop_addr`, each big-endian: `{b0[1:0],b1,b2}`.
  - After byte 5: `start<=mask & ~busy`, go to START.
- **START:** clear each `start` bit on its `ack`. Return to IDLE when `start==0`, or immediately if `mask & ~busy` was 0.
- `start_addr`, `stop_addr` and `att` stay stable while any `start` bit is set.
- CPU writes in FETCH or START are dropped.
- **Slot order.** `cen4` slots run in order ch0..ch3. A 2-bit slot counter increments on `cen4` and is 0 on the `cen4` coincident with `cen`.
- **Per-channel state:** 12-bit signed signal and step index 0..48.
- **ADPCM decode** on `cen4` with `pipe_en=1`:
  - Step table (49 entries): `step = 16,17,19,21,23,25,28,31,34,37,41,45,50,55,60,66,73,80,88,97,107,118,130,143,157,173,190,209,230,253,279,307,337,371,408,449,494,544,598,658,724,796,876,963,1060,1166,1282,1411,1552`.
  - Difference: `diff = step>>3` + (`d[0]`? `step>>2`) + (`d[1]`? `step>>1`) + (`d[2]`? `step`). Subtract if `d[3]=1`, else add.
  - Clamp the signal to [-2048, 2047].
  - Index update: `index += {-1,-1,-1,-1,2,4,6,8}[d[2:0]]`, clamped to [0, 48].
- **Inactive slot:** with `pipe_en=0`, that channel's signal and index are cleared to 0 and its contribution is 0.
- **Attenuation:** `out = (signal*gain)>>>5` with `gain[att] = 32,23,16,11,8,6,4,3,2` for att 0..8. For att 9..15 `gain=0`.
- **Mix:**
  - Accumulate the four attenuated values into a 14-bit signed accumulator. The sum cannot overflow.
  - On `cen`, `sound<=` the completed accumulator and `sample` pulses for that clk.
  - The accumulator then restarts with the current slot's value.

## Timing
- **Reset values:** FSM=IDLE; `start`, `stop`, `att`, `start_addr`, `stop_addr`, `rom_addr` = 0; `zero=0`; all signals and indexes 0; accumulator 0; `sound=0`; `sample=0`.
- Reset mid-fetch or mid-start abandons the command and clears `start`.
- ADPCM latency: the decoded, attenuated value for slot n enters the accumulator at the `cen4` after slot n's inputs. `sound` therefore reflects the previous frame.
- `stop` asserts on the clk after the write is detected.
- `start` asserts on the clk after byte 5 is latched.
- Simultaneous `ack` and `busy` changes: `ack` always clears its `start` bit.

## Test plan
- **Phrase start:** write `0x81` then `0x12` with ROM bytes `{0x00,0x10,0x00,0x00,0x20,0x00}` at addresses 8..13, `busy=0` → `start_addr=0x01000`, `stop_addr=0x02000`, `att=2`, `start=4'b0001`. Pulse `ack[0]`: `start` goes to 0 and FSM=IDLE.
- **Stop:** write `0x78` → a single-clk `stop=4'b1111`. FSM stays in IDLE.
- **Busy masking and phrase 0:** `busy=4'b0010`, write `0x80` then `0x30` → `zero=1`, `start=4'b0001`.
- **Decode:** ch0 active, att 0, nibble 0 repeated → signal 2,4,6… and index stays 0. Nibble 7 from reset → signal +30 (2+4+8+16), index 8.
- **Clamp and attenuation:** nibble 7 repeated → signal saturates at 2047 and index at 48. With att=4, contribution is 511. With att=9, contribution is 0.
- **Mix:** all four channels at 2047 with att 0 → `sound=8188`. Drop `pipe_en` for all channels → `sound=0` one frame later. `sample` pulses once per `cen`.
